// File: rtl/gfx_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gfx_rom_arbiter_pkg
//  Purpose  : Shared graphics definitions: arbiter state encoding, address
//             widths and graphics-ROM region base.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package gfx_rom_arbiter_pkg;

  // Arbiter state encoding, explicit 1-bit width.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } gfx_state_e;

  localparam int GFX_CLIENTS = 3;
  localparam int GFX_ADDR_W  = 21;
  localparam int GFX_MEM_AW  = 25;

  // Default placement of the graphics ROM inside SDRAM.
  localparam logic [GFX_MEM_AW-1:0] GFX_ROM_BASE = 25'h0;

endpackage : gfx_rom_arbiter_pkg
`default_nettype wire

// File: rtl/gfx_rom_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : gfx_rom_arbiter_rr_pick
//  Purpose  : Combinational round-robin picker. Returns the lowest pending
//             index at or after the pointer, wrapping modulo N.
//  Ports    : pend  [N-1:0]     in   pending request vector
//             ptr   [IDX_W-1:0] in   round-robin start index (< N)
//             grant [IDX_W-1:0] out  selected index (0 when none valid)
//             valid             out  at least one request pending
//  Revision : 1.0 - initial release
// ============================================================================
module gfx_rom_arbiter_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     pend,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [N-1:0]   rot;   // rot[j] = pend[(ptr + j) mod N]
  logic [IDX_W:0] sum;

  always_comb begin
    rot   = N'({pend, pend} >> ptr);
    sum   = '0;
    valid = 1'b0;
    // Scan from the far end so the smallest offset is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum   = {1'b0, ptr} + (IDX_W + 1)'(k);
        valid = 1'b1;
      end
    end
    if (sum >= (IDX_W + 1)'(N)) begin
      sum = sum - (IDX_W + 1)'(N);
    end
    grant = sum[IDX_W-1:0];
  end

endmodule : gfx_rom_arbiter_rr_pick
`default_nettype wire

// File: rtl/gfx_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gfx_rom_arbiter
//  Purpose  : Latches per-layer tile-ROM fetch requests and arbitrates them
//             round-robin onto one SDRAM controller port. Results go back to
//             the requesting layer unless a newer request superseded them.
//  Ports    : CLK_32M   in   system clock (posedge)
//             RESET_N   in   asynchronous active-low reset
//             sdr_req   in   [CLIENTS]        per-client request pulse
//             sdr_addr  in   [CLIENTS*ADDR_W] per-client byte address
//             sdr_rdy   out  [CLIENTS]        per-client data-ready pulse
//             sdr_data  out  [CLIENTS*32]     per-client returned data
//             mem_req   out  SDRAM request, held until mem_ack
//             mem_addr  out  [MEM_AW] BASE + client address
//             mem_ack   in   SDRAM completion, mem_data valid same cycle
//             mem_data  in   [32] read data
//  Revision : 1.0 - initial release
// ============================================================================
module gfx_rom_arbiter
  import gfx_rom_arbiter_pkg::*;
#(
  parameter int                CLIENTS = GFX_CLIENTS,
  parameter int                ADDR_W  = GFX_ADDR_W,
  parameter int                MEM_AW  = GFX_MEM_AW,
  parameter logic [MEM_AW-1:0] BASE    = MEM_AW'(GFX_ROM_BASE)
) (
  input  logic                      CLK_32M,
  input  logic                      RESET_N,
  input  logic [CLIENTS-1:0]        sdr_req,
  input  logic [CLIENTS*ADDR_W-1:0] sdr_addr,
  output logic [CLIENTS-1:0]        sdr_rdy,
  output logic [CLIENTS*32-1:0]     sdr_data,
  output logic                      mem_req,
  output logic [MEM_AW-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [31:0]               mem_data
);

  localparam int IDX_W = $clog2(CLIENTS);

  gfx_state_e                     state_q, state_d;
  logic [CLIENTS-1:0]             pending_q, pending_d;
  logic [CLIENTS-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]               ptr_q, ptr_d;
  logic [IDX_W-1:0]               gnt_q, gnt_d;
  logic                           stale_q, stale_d;
  logic                           mem_req_q, mem_req_d;
  logic [MEM_AW-1:0]              mem_addr_q, mem_addr_d;
  logic [CLIENTS-1:0]             rdy_q, rdy_d;
  logic [CLIENTS-1:0][31:0]       data_q, data_d;

  logic [CLIENTS-1:0][ADDR_W-1:0] req_addr;
  logic [IDX_W-1:0]               pick_idx;
  logic                           pick_valid;

  for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_addr_unpack
    assign req_addr[gi] = sdr_addr[gi*ADDR_W +: ADDR_W];
  end

  gfx_rom_arbiter_rr_pick #(
    .N     (CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .pend  (pending_q),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    stale_d    = stale_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rdy_d      = '0;
    data_d     = data_q;

    case (state_q)
      ST_IDLE: begin
        // mem_ack here is a leftover and is ignored.
        if (pick_valid) begin
          gnt_d              = pick_idx;
          mem_addr_d         = BASE + MEM_AW'(addr_q[pick_idx]);
          pending_d[pick_idx] = 1'b0;
          stale_d            = 1'b0;
          mem_req_d          = 1'b1;
          state_d            = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A fresh request from the owner supersedes the fetch in flight,
        // including one arriving together with mem_ack.
        stale_d = stale_q | sdr_req[gnt_q];
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!stale_d) begin
            rdy_d[gnt_q]  = 1'b1;
            data_d[gnt_q] = mem_data;
          end
          ptr_d   = (gnt_q == IDX_W'(CLIENTS - 1)) ? '0 : gnt_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // New requests are applied after the grant clears its flag, so a request
    // arriving on the grant cycle stays pending.
    for (int i = 0; i < CLIENTS; i++) begin
      if (sdr_req[i]) begin
        pending_d[i] = 1'b1;
        addr_d[i]    = req_addr[i];
      end
    end
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      addr_q     <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      stale_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rdy_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      stale_q    <= stale_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rdy_q      <= rdy_d;
      data_q     <= data_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign sdr_rdy  = rdy_q;
  assign sdr_data = data_q;

endmodule : gfx_rom_arbiter
`default_nettype wire

// File: tb/tb_gfx_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gfx_rom_arbiter
//  Purpose  : Self-checking bench for gfx_rom_arbiter with a transaction-level
//             reference model (pending table, round-robin pointer, in-flight
//             fetch record).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gfx_rom_arbiter;

  localparam int          N      = 3;
  localparam int          AW     = 21;
  localparam int          MAW    = 25;
  localparam logic [24:0] BASE_M = 25'h0100000;
  localparam logic [24:0] BASE_W = 25'h1FFFFFF;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*AW-1:0] addr;
  logic           ack;
  logic [31:0]    mdata;
  logic [N-1:0]   rdy,   w_rdy;
  logic [N*32-1:0] data, w_data;
  logic           mreq,  w_mreq;
  logic [MAW-1:0] maddr, w_maddr;

  gfx_rom_arbiter #(.CLIENTS(N), .ADDR_W(AW), .MEM_AW(MAW), .BASE(BASE_M)) u_dut (
    .CLK_32M(clk), .RESET_N(rst_n), .sdr_req(req), .sdr_addr(addr),
    .sdr_rdy(rdy), .sdr_data(data), .mem_req(mreq), .mem_addr(maddr),
    .mem_ack(ack), .mem_data(mdata)
  );

  gfx_rom_arbiter #(.CLIENTS(N), .ADDR_W(AW), .MEM_AW(MAW), .BASE(BASE_W)) u_wrap (
    .CLK_32M(clk), .RESET_N(rst_n), .sdr_req(req), .sdr_addr(addr),
    .sdr_rdy(w_rdy), .sdr_data(w_data), .mem_req(w_mreq), .mem_addr(w_maddr),
    .mem_ack(ack), .mem_data(mdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_pend[N];
  logic [20:0] m_addr[N];
  int          m_ptr, m_gnt;
  bit          m_busy, m_stale;
  logic [24:0] m_exp_addr, m_exp_waddr;
  logic [2:0]  m_exp_rdy;
  logic [31:0] m_exp_data[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_addr[i] = '0; m_exp_data[i] = '0;
    end
    m_ptr = 0; m_gnt = 0; m_busy = 0; m_stale = 0; m_exp_rdy = '0;
    m_exp_addr = '0; m_exp_waddr = '0;
  endtask

  // Applies the rules to the inputs that were present at the clock edge.
  task automatic model_edge();
    logic [2:0] rdy_n;
    bit found;
    rdy_n = '0;
    if (m_busy) begin
      if (req[m_gnt]) m_stale = 1;
      if (ack) begin
        if (!m_stale) begin
          rdy_n[m_gnt] = 1'b1;
          m_exp_data[m_gnt] = mdata;
        end
        m_ptr  = (m_gnt + 1) % N;
        m_busy = 0;
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && m_pend[c]) begin
          found = 1;
          m_gnt = c; m_pend[c] = 0; m_busy = 1; m_stale = 0;
          m_exp_addr  = BASE_M + {4'b0, m_addr[c]};
          m_exp_waddr = BASE_W + {4'b0, m_addr[c]};
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        m_pend[i] = 1;
        m_addr[i] = addr[i*AW +: AW];
      end
    end
    m_exp_rdy = rdy_n;
  endtask

  task automatic check_outputs();
    chk("mem_req", mreq, m_busy);
    if (m_busy) begin
      chk("mem_addr", maddr, m_exp_addr);
      chk("wrap_mem_addr", w_maddr, m_exp_waddr);
    end
    chk("sdr_rdy", rdy, m_exp_rdy);
    chk("rdy_onehot", ($countones(rdy) <= 1), 1);
    for (int i = 0; i < N; i++) chk("sdr_data", data[i*32 +: 32], m_exp_data[i]);
  endtask

  function automatic logic [N*AW-1:0] a3(input logic [20:0] a0, input logic [20:0] a1,
                                          input logic [20:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic step(input logic [2:0] r, input logic [N*AW-1:0] a, input logic k,
                      input logic [31:0] d);
    req = r; addr = a; ack = k; mdata = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    req = '0; ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; ack = 1'b0; addr = '0; mdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    chk("rst_mem_addr", maddr, 25'h0);
    rst_n = 1'b1;
  endtask

  // Acks whatever is outstanding until the port has been quiet for a while.
  task automatic drain();
    int quiet;
    quiet = 0;
    for (int n = 0; n < 60 && quiet < 3; n++) begin
      step('0, '0, mreq, $urandom);
      quiet = mreq ? 0 : quiet + 1;
    end
    chk("drain_timeout", (quiet >= 3), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   order[$];
    int   c2_cnt;
    logic [24:0] c2_addr;
    logic prev;
    logic [2:0] rereq;

    do_reset();

    // ---- single request ----
    step(3'b001, a3(21'h012340, 0, 0), 0, 0);
    chk("single_lat1_req", mreq, 0);
    step('0, '0, 0, 0);
    chk("single_req", mreq, 1);
    chk("single_addr", maddr, 25'h0112340);
    step('0, '0, 0, 0);
    step('0, '0, 1, 32'hDEADBEEF);
    chk("single_rdy", rdy, 3'b001);
    chk("single_data", data[31:0], 32'hDEADBEEF);
    chk("single_req_drop", mreq, 0);
    step('0, '0, 0, 0);
    chk("single_rdy_once", rdy, 3'b000);

    // ---- fairness ----
    do_reset();
    rereq = 3'b111; prev = 1'b0;
    for (int n = 0; n < 300 && order.size() < 9; n++) begin
      step(rereq, a3(21'd0, 21'd1, 21'd2), mreq & 1'($urandom_range(0, 1)), $urandom);
      rereq = rdy;
      if (mreq && !prev) order.push_back(int'(maddr - BASE_M));
      prev = mreq;
    end
    chk("fair_count", order.size(), 9);
    for (int i = 0; i < order.size(); i++) chk("fair_order", order[i], i % N);
    drain();

    // ---- stale ----
    do_reset();
    step(3'b010, a3(0, 21'h0AAAA0, 0), 0, 0);
    step('0, '0, 0, 0);
    chk("stale_first_addr", maddr, 25'h01AAAA0);
    step(3'b010, a3(0, 21'h055550, 0), 0, 0);
    step('0, '0, 1, 32'h11111111);
    chk("stale_no_rdy", rdy, 3'b000);
    chk("stale_no_data", data[63:32], 32'h0);
    step('0, '0, 0, 0);
    chk("stale_second_req", mreq, 1);
    chk("stale_second_addr", maddr, 25'h0155550);
    step('0, '0, 1, 32'h22222222);
    chk("stale_second_rdy", rdy, 3'b010);
    chk("stale_second_data", data[63:32], 32'h22222222);

    // ---- overwrite ----
    do_reset();
    step(3'b001, a3(21'h40, 0, 0), 0, 0);
    step('0, '0, 0, 0);
    step(3'b100, a3(0, 0, 21'h100), 0, 0);
    step(3'b100, a3(0, 0, 21'h200), 0, 0);
    step('0, '0, 1, 32'hCAFE0000);
    chk("ovw_c0_rdy", rdy, 3'b001);
    c2_cnt = 0; c2_addr = '0; prev = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step('0, '0, mreq, $urandom);
      if (mreq && !prev) begin c2_cnt++; c2_addr = maddr; end
      prev = mreq;
    end
    chk("ovw_count", c2_cnt, 1);
    chk("ovw_addr", c2_addr, 25'h0100200);

    // ---- randomized traffic ----
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [2:0] r;
      logic k;
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 5) == 0);
      k = mreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      step(r, a3(21'($urandom), 21'($urandom), 21'($urandom)), k, $urandom);
    end
    drain();

    // ---- reset while busy ----
    do_reset();
    step(3'b001, a3(21'h777, 0, 0), 0, 0);
    step('0, '0, 0, 0);
    chk("rstb_busy", mreq, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstb_async_req", mreq, 0);
    chk("rstb_async_addr", maddr, 25'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step('0, '0, 1, 32'h99999999);
    chk("rstb_stray_rdy", rdy, 3'b000);
    chk("rstb_stray_req", mreq, 0);
    step('0, '0, 0, 0);
    chk("rstb_idle_req", mreq, 0);
    chk("rstb_data", data, 96'h0);

    // ---- address wrap ----
    do_reset();
    step(3'b001, a3(21'h2, 0, 0), 0, 0);
    step('0, '0, 0, 0);
    chk("wrap_addr", w_maddr, 25'h0000001);
    chk("wrap_main_addr", maddr, 25'h0100002);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_gfx_rom_arbiter
`default_nettype wire

// File: doc/gfx_rom_arbiter.md
# gfx_rom_arbiter

Services tile-ROM fetch requests from the background layers on the SDRAM side. Each layer raises a one-cycle request with a byte address and later expects a one-cycle ready pulse with 32 bits of pixel data. This block latches requests per client and arbitrates them round-robin onto a single SDRAM controller port. It returns each result to the requesting layer and discards results that a newer request has superseded. It sits between the layer instances and the SDRAM controller's graphics-ROM channel.

## Interface
Parameters:
- CLIENTS, 3, number of layer request ports (2..4).
- ADDR_W, 21, client byte-address width.
- MEM_AW, 25, SDRAM byte-address width.
- BASE, 25'h0, graphics-ROM region base added to every client address.

Ports:
- CLK_32M  in  1  system clock; all logic on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- sdr_req  in  CLIENTS  per-client one-cycle request pulse.
- sdr_addr  in  CLIENTS*ADDR_W  per-client byte address, valid when the matching sdr_req is high.
- sdr_rdy  out  CLIENTS  per-client one-cycle data-ready pulse.
- sdr_data  out  CLIENTS*32  per-client returned data, held until that client's next sdr_rdy.
- mem_req  out  1  request to SDRAM controller, level; held until mem_ack.
- mem_addr  out  MEM_AW  BASE + zero-extended client address; stable while mem_req is high.
- mem_ack  in  1  one-cycle completion; mem_data valid in the same cycle.
- mem_data  in  32  read data.

## Operation
- Per client there is a pending flag and an address latch. On sdr_req[i], the latch takes sdr_addr and pending[i] is set. A repeated request overwrites the latch, so the latest address wins and nothing queues deeper.
- State machine:
  - IDLE: if any pending is set, grant the client with the lowest index at or after the round-robin pointer. On grant: copy its address to mem_addr, clear its pending flag, record the granted index, assert mem_req, go to BUSY.
  - BUSY: mem_req stays high and mem_addr stays stable. On mem_ack:
    - drop mem_req;
    - if the granted client is not stale, write mem_data into its sdr_data register and pulse its sdr_rdy on the next cycle;
    - advance the pointer to granted+1 (mod CLIENTS);
    - return to IDLE.
- Stale rule: an sdr_req from the granted client while in BUSY (including the mem_ack cycle) marks the in-flight fetch stale. A stale fetch produces no sdr_rdy and no sdr_data update. The new request stays pending as normal.
- A request from any other client during BUSY is simply latched as pending.
- mem_ack in IDLE is ignored.
- Address arithmetic: mem_addr = BASE + {zeros, addr}, modulo 2^MEM_AW, with no saturation.
- Reset values: mem_req=0, mem_addr=0, all sdr_rdy=0, all sdr_data=0, pending=0, pointer=0, state IDLE.
- Reset asserted mid-transaction aborts everything. A mem_ack arriving after release finds IDLE and is ignored.

## Timing
- sdr_req sampled at edge k → pending set after k. If the block is IDLE after k, mem_req is high after edge k+1. Minimum request-to-mem_req latency is 2 cycles.
- mem_ack at edge m → mem_req low after m; sdr_rdy[i] high for exactly the cycle after m; sdr_data[i] valid from the same cycle.
- IDLE is re-entered after m, so the next grant raises mem_req after m+1. There is a 1-cycle gap between back-to-back transactions.
- At most one sdr_rdy bit is high in any cycle.
- Round-robin fairness: with all clients continuously pending, each is granted once per CLIENTS transactions.

## Structure
- The shared graphics package holds:
  - the state enum (IDLE, BUSY);
  - GFX_ADDR_W=21;
  - the SDRAM address width constant;
  - the graphics-ROM base constants used by the top level.
- One natural sub-module is rr_pick. It is combinational: inputs are the pending vector and the pointer; outputs are the grant index and a valid flag. It is reusable by the sprite fetch path.

## Test plan
- Single request: reset, pulse sdr_req[0] with addr 21'h012340 and BASE=25'h100000 → mem_req after 2 cycles with mem_addr 25'h112340. Ack with mem_data 32'hDEADBEEF → sdr_rdy[0] pulses once the next cycle and sdr_data[0]=DEADBEEF.
- Fairness: pulse all three clients in one cycle and repeat each after its rdy for 9 transactions → grant order 0,1,2,0,1,2,0,1,2. No client is skipped.
- Stale: client 1 granted at addr A. Re-request at addr B during BUSY, then ack → no sdr_rdy[1]. Next mem_addr=BASE+B, and its ack yields sdr_rdy[1] with the second data word.
- Overwrite: client 2 issues addrs 0x100 then 0x200 while client 0 is busy → exactly one client-2 transaction, at BASE+0x200.
- Reset mid-BUSY: assert RESET_N low while mem_req=1, release, then drive a stray mem_ack → all outputs at reset values, with no sdr_rdy and no mem_req.
- Wrap: BASE=25'h1FFFFFF, addr 21'h2 → mem_addr 25'h0000001.
